// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: lets two requesters share one combinational ALU.
// Arbitration is round-robin between the two requesters. The winner's operands
// and opcode are registered onto the ALU inputs and held there for the opcode's
// latency. The ALU outputs are then captured into a one-cycle response.
module alu_share_ctrl #(
    parameter int          DATA_W       = 32,
    parameter int          OP_W         = 6,
    parameter logic [63:0] SLOW_OP_MASK = 64'h0000_0000_0000_0020,
    parameter int          SLOW_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_high,
    input  logic              alu_carry,
    input  logic              alu_z,
    input  logic              alu_sign,
    input  logic              alu_ovf,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [DATA_W-1:0] rsp_high,
    output logic [3:0]        rsp_flags,
    output logic              busy
);

    // The down-counter holds at most SLOW_LAT-1 and is never narrower than one bit.
    localparam int CNT_W = (SLOW_LAT > 2) ? $clog2(SLOW_LAT) : 1;
    localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(SLOW_LAT - 1);
    localparam logic [CNT_W-1:0] FAST_CNT = '0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              owner_reg, owner_next;
    logic              last_grant_reg, last_grant_next;
    logic [DATA_W-1:0] alu_a_reg, alu_a_next;
    logic [DATA_W-1:0] alu_b_reg, alu_b_next;
    logic [OP_W-1:0]   alu_op_reg, alu_op_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_id_reg, rsp_id_next;
    logic [DATA_W-1:0] rsp_result_reg, rsp_result_next;
    logic [DATA_W-1:0] rsp_high_reg, rsp_high_next;
    logic [3:0]        rsp_flags_reg, rsp_flags_next;

    // Requesters gathered into arrays so the arbiter and the mux index by grant.
    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_a  [0:1];
    logic [DATA_W-1:0] req_b  [0:1];
    logic [OP_W-1:0]   req_op [0:1];
    logic [1:0]        ready;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;
    logic              sel_slow;

    assign req_valid = {req1_valid, req0_valid};
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;

    // Round-robin: a lone requester wins. On contention the one not served last wins.
    always_comb begin
        grant = req_valid[1];
        if (&req_valid) begin
            grant = ~last_grant_reg;
        end
    end

    // Ready is only offered while idle. It goes to the granted requester, and only if that requester is still valid.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready[gi] = (state_reg == IDLE) && req_valid[gi] && (grant == 1'(gi));
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = |ready;

    assign sel_a    = req_a[grant];
    assign sel_b    = req_b[grant];
    assign sel_op   = req_op[grant];
    assign sel_slow = SLOW_OP_MASK[sel_op];

    // Next-state and datapath updates: load on accept, count down in EXEC, capture on the last EXEC cycle.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        alu_op_next     = alu_op_reg;
        rsp_valid_next  = 1'b0;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_high_next   = rsp_high_reg;
        rsp_flags_next  = rsp_flags_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    alu_a_next      = sel_a;
                    alu_b_next      = sel_b;
                    alu_op_next     = sel_op;
                    last_grant_next = grant;
                    owner_next      = grant;
                    cnt_next        = sel_slow ? SLOW_CNT : FAST_CNT;
                    state_next      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    // The ALU inputs have been stable for the full latency, so its outputs are final.
                    rsp_valid_next  = 1'b1;
                    rsp_id_next     = owner_reg;
                    rsp_result_next = alu_result;
                    rsp_high_next   = alu_high;
                    rsp_flags_next  = {alu_carry, alu_z, alu_sign, alu_ovf};
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight op and favours requester 0 next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_high_reg   <= '0;
            rsp_flags_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_op_reg     <= alu_op_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_high_reg   <= rsp_high_next;
            rsp_flags_reg  <= rsp_flags_next;
        end
    end

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_op     = alu_op_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_high   = rsp_high_reg;
    assign rsp_flags  = rsp_flags_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl.
// A stub ALU is attached to the DUT. A scoreboard queue holds one expected
// response per accepted request, and each response is checked against it.
module tb_alu_share_ctrl;

    localparam int DATA_W   = 32;
    localparam int OP_W     = 6;
    localparam int SLOW_LAT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result, alu_high;
    logic [OP_W-1:0]   alu_op;
    logic              alu_carry, alu_z, alu_sign, alu_ovf;
    logic              rsp_valid, rsp_id, busy;
    logic [DATA_W-1:0] rsp_result, rsp_high;
    logic [3:0]        rsp_flags;

    int errors = 0;
    int checks = 0;
    logic [31:0] cyc_cnt = '0;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic [31:0] high;
        logic [3:0]  flags;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    alu_share_ctrl #(
        .DATA_W(DATA_W), .OP_W(OP_W),
        .SLOW_OP_MASK(64'h0000_0000_0000_0020), .SLOW_LAT(SLOW_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_high(alu_high),
        .alu_carry(alu_carry), .alu_z(alu_z), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_high(rsp_high), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

    // Stub ALU behaviour: {high, result, carry, z, sign, ovf}.
    function automatic logic [67:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [63:0] prod;
        logic [31:0] res, high;
        logic        carry, ovf;
        high = '0; carry = 1'b0; ovf = 1'b0;
        case (op)
            6'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                res = wide[31:0]; carry = wide[32];
                ovf = (a[31] == b[31]) && (res[31] != a[31]);
            end
            6'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                res = wide[31:0]; carry = wide[32];
                ovf = (a[31] != b[31]) && (res[31] != a[31]);
            end
            6'd5: begin
                prod = {32'd0, a} * {32'd0, b};
                res = prod[31:0]; high = prod[63:32]; carry = |high;
            end
            default: begin
                res = a ^ b; high = a & b;
            end
        endcase
        return {high, res, carry, (res == 32'd0), res[31], ovf};
    endfunction

    always_comb {alu_high, alu_result, alu_carry, alu_z, alu_sign, alu_ovf} = alu_model(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic id, input logic [31:0] a, input logic [31:0] b,
                                      input logic [5:0] op, input logic [31:0] now);
        exp_t e;
        e.id = id;
        {e.high, e.res, e.flags} = alu_model(op, a, b);
        e.cyc = now + ((op == 6'd5) ? 32'(SLOW_LAT + 1) : 32'd2);
        return e;
    endfunction

    // Monitor on the falling edge: check every response against the queue, then queue any new accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 68'(rsp_valid), 68'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("rsp id=%0d result=%h high=%h flags=%b cycle=%0d",
                             rsp_id, rsp_result, rsp_high, rsp_flags, cyc_cnt);
                    check("sb_id", 68'(rsp_id), 68'(e.id));
                    check("sb_result", 68'(rsp_result), 68'(e.res));
                    check("sb_high", 68'(rsp_high), 68'(e.high));
                    check("sb_flags", 68'(rsp_flags), 68'(e.flags));
                    check("sb_latency", 68'(cyc_cnt), 68'(e.cyc));
                end
            end
            check("single_ready", 68'(req0_ready & req1_ready), 68'(0));
            if (req0_ready) sb.push_back(make_exp(1'b0, req0_a, req0_b, req0_op, cyc_cnt));
            if (req1_ready) sb.push_back(make_exp(1'b1, req1_a, req1_b, req1_op, cyc_cnt));
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_drained"}, 68'(sb.size()), 68'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_g, acc0, acc1;
        int   seen;
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 68'(busy), 68'(0));
        check("rst_alu_a", 68'(alu_a), 68'(0));
        check("rst_rsp_valid", 68'(rsp_valid), 68'(0));
        check("rst_rsp_result", 68'(rsp_result), 68'(0));
        rst = 1'b0;

        // Single fast add from requester 0.
        @(posedge clk); #1;
        req0_valid = 1; req0_a = 32'd4; req0_b = 32'hFFFF_FFFA; req0_op = 6'd0;
        #1 check("t1_ready0", 68'(req0_ready), 68'(1));
        @(posedge clk); #1;
        req0_valid = 0;
        check("t1_alu_a", 68'(alu_a), 68'(32'd4));
        check("t1_alu_b", 68'(alu_b), 68'(32'hFFFF_FFFA));
        check("t1_busy", 68'(busy), 68'(1));
        @(posedge clk); #1;
        check("t1_rsp_valid", 68'(rsp_valid), 68'(1));
        check("t1_rsp_id", 68'(rsp_id), 68'(0));
        check("t1_rsp_result", 68'(rsp_result), 68'(32'hFFFF_FFFE));
        check("t1_rsp_flags", 68'(rsp_flags), 68'(4'b0010));

        // Both requesters valid back-to-back. Requester 0 was served last, so 1 wins first.
        req0_valid = 1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 6'd0;
        req1_valid = 1; req1_a = 32'd7;  req1_b = 32'd9;  req1_op = 6'd1;
        exp_g = 1'b1; acc0 = 0; acc1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (acc0) begin req0_a = req0_a + 32'd3; req0_b = req0_b ^ 32'h55; end
                if (acc1) begin req1_a = req1_a * 32'd5 + 32'd1; end
            end
            #1;
            acc0 = req0_ready; acc1 = req1_ready;
            if (k % 2 == 0) begin
                check("t2_ready0", 68'(req0_ready), 68'(exp_g == 1'b0));
                check("t2_ready1", 68'(req1_ready), 68'(exp_g == 1'b1));
                exp_g = ~exp_g;
            end else begin
                check("t2_exec_noready", 68'({req0_ready, req1_ready}), 68'(0));
            end
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        drain("t2");

        // Slow op from requester 1 while requester 0 waits.
        req1_valid = 1; req1_a = 32'h1234; req1_b = 32'h10; req1_op = 6'd5;
        #1 check("t3_ready1", 68'(req1_ready), 68'(1));
        @(posedge clk); #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 6'd0;
        for (int k = 1; k <= SLOW_LAT; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            check("t3_wait_ready0", 68'(req0_ready), 68'(0));
            check("t3_wait_busy", 68'(busy), 68'(1));
        end
        @(posedge clk); #1;
        check("t3_rsp_valid", 68'(rsp_valid), 68'(1));
        check("t3_rsp_id", 68'(rsp_id), 68'(1));
        check("t3_rsp_result", 68'(rsp_result), 68'(32'h0001_2340));
        check("t3_b2b_ready0", 68'(req0_ready), 68'(1));
        @(posedge clk); #1;
        req0_valid = 0;
        drain("t3");

        // Requester 0 withdraws while busy. It must get no grant, and last_grant must be unchanged.
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd5; req1_op = 6'd5;
        #1 check("t4_ready1", 68'(req1_ready), 68'(1));
        @(posedge clk); #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 6'd0;
        #1 check("t4_busy_ready0", 68'(req0_ready), 68'(0));
        @(posedge clk); #1;
        req0_valid = 0;
        drain("t4");
        req0_valid = 1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 6'd0;
        req1_valid = 1; req1_a = 32'd1; req1_b = 32'd1; req1_op = 6'd1;
        #1;
        check("t4_rr_ready0", 68'(req0_ready), 68'(1));
        check("t4_rr_ready1", 68'(req1_ready), 68'(0));
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        check("t4_then_ready1", 68'(req1_ready), 68'(1));
        @(posedge clk); #1;
        req1_valid = 0;
        drain("t4b");

        // Reset during EXEC cycle 2 of a slow op.
        req0_valid = 1; req0_a = 32'd7; req0_b = 32'd11; req0_op = 6'd5;
        #1 check("t5_ready0", 68'(req0_ready), 68'(1));
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        #1 rst = 1'b1;
        #1;
        sb.delete();
        check("t5_busy", 68'(busy), 68'(0));
        check("t5_alu_a", 68'(alu_a), 68'(0));
        check("t5_alu_b", 68'(alu_b), 68'(0));
        check("t5_alu_op", 68'(alu_op), 68'(0));
        check("t5_rsp_id", 68'(rsp_id), 68'(0));
        check("t5_rsp_result", 68'(rsp_result), 68'(0));
        check("t5_rsp_flags", 68'(rsp_flags), 68'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("t5_no_rsp", 68'(seen), 68'(0));
        req0_valid = 1; req0_a = 32'd2; req0_b = 32'd3; req0_op = 6'd0;
        req1_valid = 1; req1_a = 32'd5; req1_b = 32'd6; req1_op = 6'd0;
        #1;
        check("t5_post_ready0", 68'(req0_ready), 68'(1));
        check("t5_post_ready1", 68'(req1_ready), 68'(0));
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        check("t5_post2_ready1", 68'(req1_ready), 68'(1));
        @(posedge clk); #1;
        req1_valid = 0;
        drain("t5");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
